// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Purpose: control end of the pipeline-register interface. Produces the
// enable/clear pairs for the PC, IF/ID, ID/EX and EX/MEM registers from
// load-use hazards, taken-branch flushes, multi-cycle MDU occupancy of EX
// and data-memory wait states. A two-state machine (RUN / MDU_WAIT) with a
// down-counter holds the MDU stall; every enable/clear output is
// combinational from the state and the current inputs.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   id_rs, id_rt   source specifiers of the instruction in ID
//   ex_rt          destination of the load in EX
//   ex_mem_read    instruction in EX is a load
//   branch_taken   branch/jump resolved taken in EX
//   mdu_start      MDU instruction is in EX
//   mem_stall      data memory not ready this cycle
//   pc_enable, ifid_enable/ifid_clear, idex_enable/idex_clear,
//   exmem_enable/exmem_clear   pipeline-register controls
//   stall_cycles   count of cycles with pc_enable=0 (wraps at 2^32)
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> 32-bit stall_cycles counter is implemented
//   undefined -> no counter flops, stall_cycles tied to 0
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int MDU_LATENCY = 4,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  input  logic                  mdu_start,
  input  logic                  mem_stall,
  output logic                  pc_enable,
  output logic                  ifid_enable,
  output logic                  ifid_clear,
  output logic                  idex_enable,
  output logic                  idex_clear,
  output logic                  exmem_enable,
  output logic                  exmem_clear,
  output logic [31:0]           stall_cycles
);

  localparam int CNT_W = $clog2(MDU_LATENCY);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MDU_WAIT = 1'b1;

  // Entry cycle plus the wait cycles with cnt!=0 give MDU_LATENCY-1 stall cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 2);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [0:0]       w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_load_use;

  // Load-use hazard: a load in EX writes a register the ID instruction reads ($0 never hazards).
  assign w_load_use = ex_mem_read & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

  // Output decode and next-state logic; priority is reset, mem_stall, then state rules.
  always_comb begin
    pc_enable    = 1'b1;
    ifid_enable  = 1'b1;
    ifid_clear   = 1'b0;
    idex_enable  = 1'b1;
    idex_clear   = 1'b0;
    exmem_enable = 1'b1;
    exmem_clear  = 1'b0;
    w_next_state = r_state;
    w_next_cnt   = r_cnt;

    if (!reset) begin
      // Pipeline flush while reset is held: clears win because enables stay high.
      ifid_clear   = 1'b1;
      idex_clear   = 1'b1;
      exmem_clear  = 1'b1;
      w_next_state = ST_RUN;
      w_next_cnt   = '0;
    end else if (mem_stall) begin
      // Everything freezes, including state and cnt.
      pc_enable    = 1'b0;
      ifid_enable  = 1'b0;
      idex_enable  = 1'b0;
      exmem_enable = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (branch_taken) begin
            ifid_clear = 1'b1;
            idex_clear = 1'b1;
          end else if (mdu_start) begin
            // MDU outranks load-use; EX/MEM gets bubbles until the result is ready.
            pc_enable    = 1'b0;
            ifid_enable  = 1'b0;
            idex_enable  = 1'b0;
            exmem_clear  = 1'b1;
            w_next_state = ST_MDU_WAIT;
            w_next_cnt   = CNT_LOAD;
          end else if (w_load_use) begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_clear  = 1'b1;
          end else begin
            pc_enable = 1'b1;
          end
        end
        ST_MDU_WAIT: begin
          if (r_cnt != '0) begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_enable = 1'b0;
            exmem_clear = 1'b1;
            w_next_cnt  = r_cnt - CNT_W'(1);
          end else begin
            // Release cycle: EX/MEM captures the MDU result on this edge.
            w_next_state = ST_RUN;
          end
        end
        default: begin
          w_next_state = ST_RUN;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  // State and MDU counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  // Performance counter of PC-stalled cycles; wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cycles <= 32'd0;
    end else if (!pc_enable) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Directed-vector bench for hazard_stall_ctrl (MDU_LATENCY=4). Inputs change
// on the falling edge; outputs are sampled 2 time units later, well before
// the next rising edge. Output vector order:
//   {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr}
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam logic [6:0] O_DEF = 7'b1101010;
  localparam logic [6:0] O_RST = 7'b1111111;
  localparam logic [6:0] O_LU  = 7'b0001110;
  localparam logic [6:0] O_BR  = 7'b1111110;
  localparam logic [6:0] O_MDU = 7'b0000011;
  localparam logic [6:0] O_MS  = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_mem_read, branch_taken, mdu_start, mem_stall;
  logic        pc_enable, ifid_enable, ifid_clear, idex_enable, idex_clear;
  logic        exmem_enable, exmem_clear;
  logic [31:0] stall_cycles;
  logic [6:0]  outs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MDU_LATENCY(4), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .mdu_start(mdu_start), .mem_stall(mem_stall),
    .pc_enable(pc_enable), .ifid_enable(ifid_enable), .ifid_clear(ifid_clear),
    .idex_enable(idex_enable), .idex_clear(idex_clear),
    .exmem_enable(exmem_enable), .exmem_clear(exmem_clear),
    .stall_cycles(stall_cycles)
  );

  assign outs = {pc_enable, ifid_enable, ifid_clear, idex_enable, idex_clear,
                 exmem_enable, exmem_clear};

  // Expected counter value depends on whether the counter is built.
  function automatic logic [31:0] exp_cnt(input logic [31:0] n);
`ifdef HAZARD_PERF_CNT_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    ex_mem_read = 1'b0; branch_taken = 1'b0; mdu_start = 1'b0; mem_stall = 1'b0;
  endtask

  // Check combinational outputs for the current inputs, then advance one cycle.
  task automatic cyc(input string tag, input logic [6:0] exp);
    #2;
    check_eq(tag, {25'd0, outs}, {25'd0, exp});
    @(negedge clk);
  endtask

  task automatic set_load_use(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert);
    idle_inputs();
    ex_mem_read = 1'b1; id_rs = rs; id_rt = rt; ex_rt = ert;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    cyc("reset_outs", O_RST);
    cyc("reset_outs2", O_RST);
    reset = 1'b1;
    #2 check_eq("cnt_after_reset", stall_cycles, 32'd0);
    cyc("idle", O_DEF);

    // Load-use hazards
    set_load_use(5'd8, 5'd0, 5'd8);
    cyc("lu_rs", O_LU);                         // +1
    set_load_use(5'd8, 5'd0, 5'd0);
    cyc("lu_rt0_none", O_DEF);
    set_load_use(5'd3, 5'd9, 5'd9);
    cyc("lu_rt", O_LU);                         // +1
    set_load_use(5'd3, 5'd4, 5'd9);
    cyc("lu_nomatch", O_DEF);
    set_load_use(5'd0, 5'd9, 5'd9);
    branch_taken = 1'b1;
    cyc("br_over_lu", O_BR);
    idle_inputs();
    cyc("idle2", O_DEF);

    // MDU with mdu_start held 4 cycles; branch ignored while waiting
    mdu_start = 1'b1;
    cyc("mdu_c0", O_MDU);                       // +1
    cyc("mdu_c1", O_MDU);                       // +1
    branch_taken = 1'b1;
    cyc("mdu_c2_br_ign", O_MDU);                // +1
    branch_taken = 1'b0;
    cyc("mdu_c3_release", O_DEF);
    mdu_start = 1'b0;
    set_load_use(5'd8, 5'd0, 5'd8);             // proves state is RUN
    cyc("mdu_c4_run", O_LU);                    // +1
    idle_inputs();
    check_eq("cnt_6", stall_cycles, exp_cnt(32'd6));
    cyc("idle3", O_DEF);

    // MDU interrupted by mem_stall at cycles 1-2
    mdu_start = 1'b1;
    cyc("ms_c0", O_MDU);                        // +1
    mdu_start = 1'b0;
    mem_stall = 1'b1;
    cyc("ms_c1", O_MS);                         // +1
    cyc("ms_c2", O_MS);                         // +1
    mem_stall = 1'b0;
    cyc("ms_c3", O_MDU);                        // +1
    cyc("ms_c4", O_MDU);                        // +1
    cyc("ms_c5_release", O_DEF);
    set_load_use(5'd8, 5'd0, 5'd8);
    mem_stall = 1'b1;
    cyc("ms_over_lu", O_MS);                    // +1
    idle_inputs();
    check_eq("cnt_12", stall_cycles, exp_cnt(32'd12));
    cyc("idle4", O_DEF);

    // Reset in the middle of an MDU wait
    mdu_start = 1'b1;
    cyc("rst_mdu_c0", O_MDU);                   // +1
    mdu_start = 1'b0;
    reset = 1'b0;
    #2 check_eq("cnt_13", stall_cycles, exp_cnt(32'd13));
    cyc("rst_mid_mdu", O_RST);
    reset = 1'b1;
    check_eq("cnt_cleared", stall_cycles, 32'd0);
    cyc("after_rst_run", O_DEF);
    mdu_start = 1'b1;
    cyc("rst_mdu2_c0", O_MDU);
    cyc("rst_mdu2_c1", O_MDU);
    cyc("rst_mdu2_c2", O_MDU);
    mdu_start = 1'b0;
    cyc("rst_mdu2_release", O_DEF);
    set_load_use(5'd0, 5'd7, 5'd7);
    mdu_start = 1'b1;                           // MDU rule wins over load-use
    cyc("mdu_over_lu", O_MDU);
    idle_inputs();
    cyc("mdu_over_lu_c1", O_MDU);
    cyc("mdu_over_lu_c2", O_MDU);
    cyc("mdu_over_lu_rel", O_DEF);
    set_load_use(5'd5, 5'd0, 5'd5);
    cyc("perf_lu", O_LU);
    idle_inputs();
    // After reset: 3 (MDU) + 3 (MDU) + 1 (load-use)
    #2 check_eq("cnt_perf", stall_cycles, exp_cnt(32'd7));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
